// File: rtl/sr_flag_scheduler.sv
// sr_flag_scheduler: round-robin arbiter applying SR set/clear commands to a shared flag bank, with a sequenced full-bank sweep
// Ports: clk, rst (async active-low); req_valid/req_idx/req_op in, req_ready out (one-hot grant);
// sweep_start, err_clr in; flags, flags_bar, grant_valid, grant_id, busy, sweep_done, err out.
module sr_flag_scheduler #(
  parameter int NREQ = 4,
  parameter int NFLAG = 8,
  parameter int IW = $clog2(NFLAG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*IW-1:0]       req_idx,
  input  logic [2*NREQ-1:0]        req_op,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     sweep_start,
  input  logic                     err_clr,
  output logic [NFLAG-1:0]         flags,
  output logic [NFLAG-1:0]         flags_bar,
  output logic                     grant_valid,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     sweep_done,
  output logic                     err
);
  localparam int GW = $clog2(NREQ);
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state_q, state_d;
  logic [NFLAG-1:0] flags_q, flags_d;
  logic [GW-1:0] ptr_q, ptr_d, grant_id_q, grant_id_d, gid, hi_id, lo_id;
  logic [IW-1:0] cnt_q, cnt_d, idx;
  logic [1:0] op;
  logic grant_valid_q, grant_valid_d, sweep_done_q, sweep_done_d, err_q, err_d;
  logic hi_found, lo_found, found, xfer, in_range, err_set;
  // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid below ptr.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id = '0;
    lo_id = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req_valid[j] && j >= int'(ptr_q)) begin
        hi_found = 1'b1;
        hi_id = GW'(j);
      end
      if (req_valid[j] && j < int'(ptr_q)) begin
        lo_found = 1'b1;
        lo_id = GW'(j);
      end
    end
    found = hi_found | lo_found;
    gid = hi_found ? hi_id : lo_id;
  end
  always_comb begin
    xfer = (state_q == IDLE) && !sweep_start && found;
    op = req_op[2*gid +: 2];
    idx = req_idx[gid*IW +: IW];
    in_range = 32'(idx) < NFLAG;
    err_set = xfer && (op == 2'b11 || !in_range);
    req_ready = xfer ? (NREQ'(1) << gid) : '0;
    flags_d = flags_q;
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    sweep_done_d = 1'b0;
    grant_valid_d = xfer;
    grant_id_d = xfer ? gid : grant_id_q;
    err_d = err_set | (err_q & ~err_clr);
    if (state_q == SWEEP) begin
      flags_d[cnt_q] = 1'b0;
      cnt_d = cnt_q + IW'(1);
      if (32'(cnt_q) == NFLAG - 1) begin
        state_d = IDLE;
        cnt_d = '0;
        sweep_done_d = 1'b1;
      end
    end else if (sweep_start) begin
      state_d = SWEEP;
      cnt_d = '0;
    end else if (xfer) begin
      ptr_d = (32'(gid) == NREQ - 1) ? '0 : gid + GW'(1);
      if (in_range && op == 2'b01) flags_d[idx] = 1'b0;
      if (in_range && op == 2'b10) flags_d[idx] = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      flags_q <= '0;
      cnt_q <= '0;
      ptr_q <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q <= '0;
      sweep_done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q <= grant_id_d;
      sweep_done_q <= sweep_done_d;
      err_q <= err_d;
    end
  end
  assign flags = flags_q;
  assign flags_bar = ~flags_q;
  assign grant_valid = grant_valid_q;
  assign grant_id = grant_id_q;
  assign busy = state_q == SWEEP;
  assign sweep_done = sweep_done_q;
  assign err = err_q;
endmodule

// File: tb/tb_sr_flag_scheduler.sv
// tb_sr_flag_scheduler: directed stimulus with a queue-based reference model and per-cycle comparison
module tb_sr_flag_scheduler;
  localparam int NREQ = 4;
  localparam int NFLAG = 8;
  localparam int IW = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*IW-1:0] req_idx;
  logic [2*NREQ-1:0] req_op;
  logic sweep_start, err_clr;
  logic [NFLAG-1:0] flags, flags_bar;
  logic grant_valid, busy, sweep_done, err;
  logic [1:0] grant_id;
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  logic [NFLAG-1:0] m_flags = '0;
  int m_ptr = 0;
  int m_gid = 0;
  int m_g, m_ix, m_c;
  bit m_err = 1'b0;
  bit m_gv = 1'b0;
  bit m_done = 1'b0;
  bit m_eset;
  logic [1:0] m_op;
  int sweep_q[$];
  sr_flag_scheduler #(.NREQ(NREQ), .NFLAG(NFLAG)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_idx(req_idx), .req_op(req_op),
    .req_ready(req_ready), .sweep_start(sweep_start), .err_clr(err_clr), .flags(flags),
    .flags_bar(flags_bar), .grant_valid(grant_valid), .grant_id(grant_id), .busy(busy),
    .sweep_done(sweep_done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int pick();
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction
  function automatic logic [NREQ-1:0] exp_ready();
    int g;
    g = pick();
    if (sweep_q.size() > 0 || sweep_start || g < 0) return '0;
    return NREQ'(1) << g;
  endfunction
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_flags = '0;
      m_ptr = 0;
      m_err = 1'b0;
      m_gv = 1'b0;
      m_gid = 0;
      m_done = 1'b0;
      sweep_q.delete();
    end else begin
      m_g = pick();
      m_eset = 1'b0;
      m_gv = 1'b0;
      m_done = 1'b0;
      if (sweep_q.size() > 0) begin
        m_c = sweep_q.pop_front();
        m_flags[m_c] = 1'b0;
        m_done = sweep_q.size() == 0;
      end else if (sweep_start) begin
        for (int i = 0; i < NFLAG; i++) sweep_q.push_back(i);
      end else if (m_g >= 0) begin
        m_op = req_op[2*m_g +: 2];
        m_ix = int'(req_idx[m_g*IW +: IW]);
        m_gv = 1'b1;
        m_gid = m_g;
        m_ptr = (m_g + 1) % NREQ;
        if (m_ix >= NFLAG || m_op == 2'b11) m_eset = 1'b1;
        else if (m_op == 2'b10) m_flags[m_ix] = 1'b1;
        else if (m_op == 2'b01) m_flags[m_ix] = 1'b0;
      end
      m_err = m_eset ? 1'b1 : (err_clr ? 1'b0 : m_err);
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("cmp_ready", req_ready, exp_ready());
    chk("cmp_flags", flags, m_flags);
    chk("cmp_flags_bar", flags_bar, m_flags ^ 8'hFF);
    chk("cmp_busy", busy, sweep_q.size() > 0);
    chk("cmp_err", err, m_err);
    chk("cmp_gv", grant_valid, m_gv);
    if (m_gv) chk("cmp_gid", grant_id, m_gid);
    chk("cmp_done", sweep_done, m_done);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic setr(input int i, input bit v, input int ix, input logic [1:0] op);
    req_valid[i] = v;
    req_idx[i*IW +: IW] = IW'(ix);
    req_op[2*i +: 2] = op;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end
  initial begin
    int pulses, bc, dc;
    logic [7:0] e;
    req_valid = '0;
    req_idx = '0;
    req_op = '0;
    sweep_start = 1'b0;
    err_clr = 1'b0;
    #12 rst = 1'b0;
    #1;
    chk("rst_flags", flags, 8'h00);
    chk("rst_flags_bar", flags_bar, 8'hFF);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    tick();
    tick();
    rst = 1'b1;
    chk_en = 1'b1;
    chk("rst_ready", req_ready, 0);
    setr(2, 1, 5, 2'b10);
    tick();
    chk("set5_flags", flags, 8'h20);
    chk("set5_gid", grant_id, 2);
    chk("set5_gv", grant_valid, 1);
    setr(2, 1, 5, 2'b01);
    tick();
    chk("clr5_flags", flags, 8'h00);
    chk("clr5_gid", grant_id, 2);
    setr(2, 0, 0, 2'b00);
    setr(3, 1, 0, 2'b00);
    tick();
    chk("hold_flags", flags, 8'h00);
    chk("hold_gid", grant_id, 3);
    for (int i = 0; i < NREQ; i++) setr(i, 1, i, 2'b10);
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("rr_gid", grant_id, n % 4);
    end
    chk("rr_flags", flags, 8'h0F);
    for (int i = 0; i < NREQ; i++) setr(i, 0, 0, 2'b00);
    setr(1, 1, 0, 2'b11);
    tick();
    chk("ill_err", err, 1);
    chk("ill_flags", flags, 8'h0F);
    chk("ill_gid", grant_id, 1);
    err_clr = 1'b1;
    tick();
    chk("ill_clr_same", err, 1);
    setr(1, 0, 0, 2'b00);
    tick();
    chk("err_clr", err, 0);
    err_clr = 1'b0;
    for (int i = 0; i < NREQ; i++) setr(i, 1, i + 4, 2'b10);
    repeat (4) tick();
    for (int i = 0; i < NREQ; i++) setr(i, 0, 0, 2'b00);
    chk("fill_flags", flags, 8'hFF);
    setr(0, 1, 0, 2'b10);
    sweep_start = 1'b1;
    #1 chk("sw_start_ready", req_ready, 0);
    tick();
    sweep_start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk("sw_ready", req_ready, 0);
      chk("sw_busy", busy, 1);
      tick();
      e = 8'hFF << k;
      chk("sw_flags", flags, e);
    end
    chk("sw_done", sweep_done, 1);
    chk("sw_busy_end", busy, 0);
    chk("post_ready", req_ready, 4'b0001);
    tick();
    chk("post_gid", grant_id, 0);
    chk("post_gv", grant_valid, 1);
    chk("post_done", sweep_done, 0);
    chk("post_flags", flags, 8'h01);
    setr(0, 0, 0, 2'b00);
    setr(3, 1, 7, 2'b10);
    tick();
    setr(3, 0, 0, 2'b00);
    chk("pre_abort_flags", flags, 8'h81);
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    repeat (3) tick();
    chk("abort_busy_pre", busy, 1);
    chk("abort_flags_pre", flags, 8'h80);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_flags", flags, 8'h00);
    tick();
    rst = 1'b1;
    pulses = 0;
    repeat (10) begin
      tick();
      pulses += int'(sweep_done);
    end
    chk("abort_no_done", pulses, 0);
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    bc = 0;
    dc = 0;
    repeat (12) begin
      bc += int'(busy);
      dc += int'(sweep_done);
      tick();
    end
    chk("resweep_busy_cycles", bc, 8);
    chk("resweep_done_pulses", dc, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
